// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//
// Purpose:
//   Reset sequencer that sits behind a PLL. It waits for the PLL lock
//   indicator to be stable for LOCK_STABLE_CYCLES clocks. It then releases
//   three per-domain resets in ascending order, STAGE_GAP clocks apart, and
//   finally raises ready. If lock never arrives within LOCK_TIMEOUT clocks,
//   it pulses pll_rst for PLL_RST_CYCLES clocks and tries again. Any loss of
//   lock once the sequence has started re-asserts every domain reset at once
//   and restarts the sequence.
//
// Parameters:
//   LOCK_STABLE_CYCLES  consecutive synchronized-lock cycles before release
//   STAGE_GAP           clk cycles between successive rst_out stage releases
//   LOCK_TIMEOUT        cycles waited without lock before pulsing pll_rst
//   PLL_RST_CYCLES      pll_rst pulse width in clk cycles
//
// Ports:
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   locked    in   PLL lock indicator, asynchronous to clk
//   pll_rst   out  active-high reset request back to the PLL
//   rst_out   out  [2:0] active-high domain resets, bit 0 released first
//   ready     out  high once all stages are released while lock is held
//   loss_cnt  out  [7:0] saturating lock-loss count (optional, see below)
//
// Configuration:
//   PLL_RESET_SEQ_LOSS_CNT_EN  when defined, adds the loss_cnt port and its
//                              saturating counter; otherwise neither exists.
// -----------------------------------------------------------------------------
module pll_reset_seq #(
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned STAGE_GAP          = 16,
  parameter int unsigned LOCK_TIMEOUT       = 65536,
  parameter int unsigned PLL_RST_CYCLES     = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic [2:0] rst_out,
  output logic       ready
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  ,
  output logic [7:0] loss_cnt
`endif
);

  // One counter serves every state. Each state uses it as a timer and clears
  // it on entry, so it only has to hold the largest terminal value
  // (parameter - 1). Every terminal compare is an equality that stops the
  // count, so the counter never wraps.
  localparam int unsigned MAX_AB  = (LOCK_STABLE_CYCLES > STAGE_GAP) ?
                                    LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int unsigned MAX_CD  = (LOCK_TIMEOUT > PLL_RST_CYCLES) ?
                                    LOCK_TIMEOUT : PLL_RST_CYCLES;
  localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int unsigned CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST     = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] PLLRST_LAST  = CW'(PLL_RST_CYCLES - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK,
    PLL_RESET,
    STABLE,
    RELEASE,
    RUN
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [2:0]    rst_out_n;
  logic          ready_n;
  logic          pll_rst_n;

  logic          sync_meta;
  logic          lock_s;

  // Two-flop synchronizer for the asynchronous lock indicator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      sync_meta <= locked;
      lock_s    <= sync_meta;
    end
  end

  // State, counter and all outputs are registered here. Reset forces every
  // domain reset on and drops ready. It does not raise pll_rst; only the
  // lock timeout does that.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= WAIT_LOCK;
      cnt     <= '0;
      rst_out <= 3'b111;
      ready   <= 1'b0;
      pll_rst <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      rst_out <= rst_out_n;
      ready   <= ready_n;
      pll_rst <= pll_rst_n;
    end
  end

  // Next-state logic. Outputs are computed as next values, so each output
  // changes on the same edge that makes the corresponding state transition.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    rst_out_n = rst_out;
    ready_n   = ready;
    pll_rst_n = pll_rst;

    unique case (state)
      WAIT_LOCK: begin
        rst_out_n = 3'b111;
        ready_n   = 1'b0;
        pll_rst_n = 1'b0;
        if (lock_s) begin
          state_n = STABLE;
          cnt_n   = '0;
        end else if (cnt == TIMEOUT_LAST) begin
          state_n   = PLL_RESET;
          cnt_n     = '0;
          pll_rst_n = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      // Lock is deliberately ignored here. The PLL is being reset, so any
      // lock seen now is stale.
      PLL_RESET: begin
        if (cnt == PLLRST_LAST) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          pll_rst_n = 1'b0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      STABLE: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          rst_out_n = 3'b111;
          ready_n   = 1'b0;
        end else if (cnt == STABLE_LAST) begin
          state_n   = RELEASE;
          cnt_n     = '0;
          rst_out_n = 3'b110;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      // The current rst_out[1] tells which stage is next. While it is still
      // asserted, stage 1 goes next; otherwise the final stage goes and the
      // FSM enters RUN.
      RELEASE: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          rst_out_n = 3'b111;
          ready_n   = 1'b0;
        end else if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (rst_out[1]) begin
            rst_out_n = 3'b100;
          end else begin
            state_n   = RUN;
            rst_out_n = 3'b000;
            ready_n   = 1'b1;
          end
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end

      RUN: begin
        if (!lock_s) begin
          state_n   = WAIT_LOCK;
          cnt_n     = '0;
          rst_out_n = 3'b111;
          ready_n   = 1'b0;
        end else begin
          rst_out_n = 3'b000;
          ready_n   = 1'b1;
        end
      end

      default: begin
        state_n   = WAIT_LOCK;
        cnt_n     = '0;
        rst_out_n = 3'b111;
        ready_n   = 1'b0;
        pll_rst_n = 1'b0;
      end
    endcase
  end

`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  // A loss event is a synchronized lock drop seen after the sequence has
  // started. Drops in WAIT_LOCK or PLL_RESET are expected, so they are not
  // counted.
  logic loss_event;

  always_comb begin
    loss_event = 1'b0;
    if (!lock_s && (state == STABLE || state == RELEASE || state == RUN)) begin
      loss_event = 1'b1;
    end
  end

  // The loss counter saturates at 255 so that a flapping PLL never makes
  // the count look healthy again.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      loss_cnt <= 8'd0;
    end else if (loss_event && (loss_cnt != 8'hFF)) begin
      loss_cnt <= loss_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pll_reset_seq.sv
// -----------------------------------------------------------------------------
// tb_pll_reset_seq
//
// Purpose:
//   Self-checking bench for pll_reset_seq. It builds the DUT with small
//   parameters (16/4/32/8). Every cycle, the outputs are compared against a
//   reference model. The model tracks only how many edges have passed since
//   lock was first seen, or since waiting began, and derives the expected
//   outputs from those counts with plain arithmetic. Directed checks pin the
//   exact release, timeout and reset edges. Randomized lock/unlock segments
//   then exercise the remaining behaviour.
//
// Configuration:
//   PLL_RESET_SEQ_LOSS_CNT_EN  when defined, loss_cnt is connected and checked.
// -----------------------------------------------------------------------------
module tb_pll_reset_seq;

  localparam int LSC = 16;
  localparam int GAP = 4;
  localparam int TMO = 32;
  localparam int PRC = 8;

  logic       clk;
  logic       rst;
  logic       locked;
  logic       pll_rst;
  logic [2:0] rst_out;
  logic       ready;
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model state. In the locked phase, m_s counts edges since the
  // model entered it. In the waiting phase, m_e counts edges since waiting
  // began. m_s1/m_ls hold the two-edge delayed view of locked.
  bit m_locked;
  int m_s;
  int m_e;
  int m_loss;
  bit m_s1;
  bit m_ls;

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES(LSC),
    .STAGE_GAP(GAP),
    .LOCK_TIMEOUT(TMO),
    .PLL_RST_CYCLES(PRC)
  ) dut (
    .clk(clk),
    .rst(rst),
    .locked(locked),
    .pll_rst(pll_rst),
    .rst_out(rst_out),
    .ready(ready)
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    ,
    .loss_cnt(loss_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // While lock stays absent, pll_rst repeats with period TMO+PRC. It is
  // high for PRC edges, starting TMO edges after waiting began.
  function automatic bit pllAt(input int e);
    int ph;
    if (e < 1) return 1'b0;
    ph = (e - 1) % (TMO + PRC);
    return (ph >= TMO - 1) && (ph < TMO - 1 + PRC);
  endfunction

  function automatic logic [2:0] expRstOut();
    if (!m_locked) return 3'b111;
    return {m_s < LSC + 2 * GAP, m_s < LSC + GAP, m_s < LSC};
  endfunction

  function automatic bit expReady();
    return m_locked && (m_s >= LSC + 2 * GAP);
  endfunction

  function automatic bit expPllRst();
    return !m_locked && pllAt(m_e);
  endfunction

  task automatic modelReset();
    m_locked = 1'b0;
    m_s      = 0;
    m_e      = 0;
    m_loss   = 0;
    m_s1     = 1'b0;
    m_ls     = 1'b0;
  endtask

  // Advance the model by one clock edge. lk is the raw locked value sampled
  // at that edge.
  task automatic modelEdge(input bit lk);
    if (m_locked) begin
      if (!m_ls) begin
        m_locked = 1'b0;
        m_e      = 0;
        if (m_loss < 255) m_loss++;
      end else begin
        m_s++;
      end
    end else begin
      if (!pllAt(m_e) && m_ls) begin
        m_locked = 1'b1;
        m_s      = 0;
      end else begin
        m_e++;
      end
    end
    m_ls = m_s1;
    m_s1 = lk;
  endtask

  task automatic checkValue(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string tag);
    checkValue({tag, "/rst_out"}, int'(rst_out), int'(expRstOut()));
    checkValue({tag, "/ready"}, int'(ready), int'(expReady()));
    checkValue({tag, "/pll_rst"}, int'(pll_rst), int'(expPllRst()));
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    checkValue({tag, "/loss_cnt"}, int'(loss_cnt), m_loss);
`endif
  endtask

  // Hold locked at lk for n clock edges. The task is called at a falling
  // edge and checks all outputs at each following falling edge.
  task automatic applyStimulus(input bit lk, input int n, input string tag);
    locked = lk;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      modelEdge(lk);
      @(negedge clk);
      checkOutput(tag);
    end
  endtask

  // Pulse rst between clock edges and check that it acts immediately. Then
  // release it at the next falling edge with locked set to lk. The next
  // rising edge is edge 1.
  task automatic doReset(input bit lk, input string tag);
    #2 rst = 1'b1;
    #1;
    modelReset();
    checkValue({tag, "/async_rst_out"}, int'(rst_out), 7);
    checkValue({tag, "/async_ready"}, int'(ready), 0);
    checkValue({tag, "/async_pll_rst"}, int'(pll_rst), 0);
    @(negedge clk);
    checkOutput({tag, "/held"});
    locked = lk;
    rst    = 1'b0;
  endtask

  // With locked high from edge 1: rst_out[0] falls at edge 19,
  // rst_out[1] at edge 23, and rst_out[2] falls with ready rising at
  // edge 27.
  task automatic checkReleaseTiming(input string tag);
    applyStimulus(1'b1, 18, tag);
    checkValue({tag, "/e18_r0"}, int'(rst_out[0]), 1);
    applyStimulus(1'b1, 1, tag);
    checkValue({tag, "/e19_r0"}, int'(rst_out[0]), 0);
    checkValue({tag, "/e19_r1"}, int'(rst_out[1]), 1);
    applyStimulus(1'b1, 3, tag);
    checkValue({tag, "/e22_r1"}, int'(rst_out[1]), 1);
    applyStimulus(1'b1, 1, tag);
    checkValue({tag, "/e23_r1"}, int'(rst_out[1]), 0);
    checkValue({tag, "/e23_r2"}, int'(rst_out[2]), 1);
    applyStimulus(1'b1, 3, tag);
    checkValue({tag, "/e26_r2"}, int'(rst_out[2]), 1);
    checkValue({tag, "/e26_ready"}, int'(ready), 0);
    applyStimulus(1'b1, 1, tag);
    checkValue({tag, "/e27_rst_out"}, int'(rst_out), 0);
    checkValue({tag, "/e27_ready"}, int'(ready), 1);
  endtask

  initial begin
    rst    = 1'b1;
    locked = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkValue("reset/rst_out", int'(rst_out), 7);
    checkValue("reset/ready", int'(ready), 0);
    checkValue("reset/pll_rst", int'(pll_rst), 0);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    checkValue("reset/loss_cnt", int'(loss_cnt), 0);
`endif

    $display("[TB] release sequence from reset");
    locked = 1'b1;
    rst    = 1'b0;
    checkReleaseTiming("seq1");

    $display("[TB] lock loss in RUN");
    applyStimulus(1'b1, 5, "run_hold");
    checkValue("run_hold/ready", int'(ready), 1);
    applyStimulus(1'b0, 2, "run_drop");
    checkValue("run_drop_e2/rst_out", int'(rst_out), 0);
    checkValue("run_drop_e2/ready", int'(ready), 1);
    applyStimulus(1'b0, 1, "run_drop");
    checkValue("run_drop_e3/rst_out", int'(rst_out), 7);
    checkValue("run_drop_e3/ready", int'(ready), 0);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    checkValue("run_drop_e3/loss_cnt", int'(loss_cnt), 1);
`endif

    $display("[TB] lock drop during STABLE, then full restart");
    applyStimulus(1'b0, 3, "settle");
    applyStimulus(1'b1, 12, "stable_part");
    applyStimulus(1'b0, 5, "stable_drop");
    checkValue("stable_drop/rst_out", int'(rst_out), 7);
    checkValue("stable_drop/ready", int'(ready), 0);
    applyStimulus(1'b1, 18, "relock");
    checkValue("relock_e18/r0", int'(rst_out[0]), 1);
    applyStimulus(1'b1, 1, "relock");
    checkValue("relock_e19/r0", int'(rst_out[0]), 0);

    $display("[TB] reset pulsed during RELEASE");
    applyStimulus(1'b1, 1, "release");
    doReset(1'b1, "mid_release");
    checkReleaseTiming("seq2");

    $display("[TB] lock timeout and pll_rst pulses");
    doReset(1'b0, "timeout");
    applyStimulus(1'b0, 31, "tmo");
    checkValue("tmo_e31/pll_rst", int'(pll_rst), 0);
    applyStimulus(1'b0, 1, "tmo");
    checkValue("tmo_e32/pll_rst", int'(pll_rst), 1);
    applyStimulus(1'b0, 7, "tmo");
    checkValue("tmo_e39/pll_rst", int'(pll_rst), 1);
    applyStimulus(1'b0, 1, "tmo");
    checkValue("tmo_e40/pll_rst", int'(pll_rst), 0);
    applyStimulus(1'b0, 31, "tmo");
    checkValue("tmo_e71/pll_rst", int'(pll_rst), 0);
    applyStimulus(1'b0, 1, "tmo");
    checkValue("tmo_e72/pll_rst", int'(pll_rst), 1);
    applyStimulus(1'b1, 10, "lock_in_pll_rst");

    $display("[TB] repeated loss events");
    doReset(1'b0, "loss_sat");
    for (int i = 0; i < 260; i++) begin
      applyStimulus(1'b1, 1, "loss_hi");
      applyStimulus(1'b0, 3, "loss_lo");
    end
    checkValue("loss_sat/rst_out", int'(rst_out), 7);
`ifdef PLL_RESET_SEQ_LOSS_CNT_EN
    checkValue("loss_sat/loss_cnt", int'(loss_cnt), 255);
`endif

    $display("[TB] randomized lock segments");
    doReset(1'b0, "random");
    for (int i = 0; i < 40; i++) begin
      applyStimulus(1'b1, int'($urandom_range(1, 60)), "rand_hi");
      applyStimulus(1'b0, int'($urandom_range(1, 50)), "rand_lo");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
